// File: rtl/uwasic_onboarding_elvis_if.sv
`default_nettype none
// ============================================================================
// Module   : uwasic_onboarding_elvis_if
// Purpose  : Tiny Tapeout tile pin bundle shared by the harness and the tile.
// Signals  : ui_in[7:0]   dedicated inputs  ([0]=SCLK, [1]=COPI, [2]=nCS)
//            uo_out[7:0]  dedicated outputs (channels 7..0)
//            uio_in[7:0]  bidirectional inputs (unused by the tile)
//            uio_out[7:0] bidirectional outputs (channels 15..8)
//            uio_oe[7:0]  bidirectional output enables
// Modports : master = harness side, slave = tile side
// Revision : 1.0  initial release
// ============================================================================
interface uwasic_onboarding_elvis_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ui_in, output uio_in, input uo_out, input uio_out, input uio_oe);
  modport slave  (input ui_in, input uio_in, output uo_out, output uio_out, output uio_oe);
endinterface
`default_nettype wire

// File: rtl/uwasic_onboarding_elvis.sv
`default_nettype none
// ============================================================================
// Module   : uwasic_onboarding_elvis
// Purpose  : Tiny Tapeout tile. A write-only SPI (mode 0) peripheral loads five
//            8-bit control registers that drive 16 output channels as static
//            levels or as a shared PWM waveform.
// Ports    : clk    system clock (rising edge)
//            rst_n  asynchronous active-low reset
//            ena    tile select (only used when ENA_GATE_EN is defined)
//            io     tile pins (slave modport of uwasic_onboarding_elvis_if)
// Params   : PWM_DIV  clk cycles per PWM counter step
//            MAX_ADDR highest writable register address
// Macros   : ENA_GATE_EN - when defined, ena = 0 forces outputs low and
//            discards SPI frames; registers keep their contents.
// Registers: 0 en_out[7:0], 1 en_out[15:8], 2 en_pwm[7:0], 3 en_pwm[15:8],
//            4 duty
// Revision : 1.0  initial release
// ============================================================================
module uwasic_onboarding_elvis #(
  parameter int PWM_DIV  = 13,
  parameter int MAX_ADDR = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              ena,
  uwasic_onboarding_elvis_if.slave io
);

  localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RX   = 1'b1
  } spi_state_t;

  // Synchronizer bit order: [0]=SCLK, [1]=COPI, [2]=nCS.
  // nCS flops reset high (idle) so reset release does not fake a frame start.
  logic [2:0]  r_sync1, r_sync2, r_prev;
  spi_state_t  r_state;
  logic [4:0]  r_bit_cnt;
  logic [15:0] r_shift;
  logic [15:0] r_en_out, r_en_pwm;
  logic [7:0]  r_duty;
  logic [PRE_W-1:0] r_pre;
  logic [7:0]  r_cnt;
  logic [15:0] r_out;

  logic w_sclk_rise, w_ncs_fall, w_ncs_rise, w_frame_ok, w_gate, w_pwm;
  logic [15:0] w_out_next;

`ifdef ENA_GATE_EN
  assign w_gate = ena;
`else
  assign w_gate = 1'b1;
`endif

  // Pins the tile never looks at.
  wire w_unused = &{1'b0, io.uio_in, io.ui_in[7:3], ena};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 3'b100;
      r_sync2 <= 3'b100;
      r_prev  <= 3'b100;
    end else begin
      r_sync1 <= io.ui_in[2:0];
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_sclk_rise = r_sync2[0] & ~r_prev[0];
  assign w_ncs_fall  = ~r_sync2[2] & r_prev[2];
  assign w_ncs_rise  = r_sync2[2] & ~r_prev[2];

  // Bit counter saturates at 17 so over-long frames can never alias to 16.
  assign w_frame_ok = (r_bit_cnt == 5'd16) && r_shift[15] &&
                      (r_shift[14:8] <= 7'(MAX_ADDR)) && w_gate;

  // SPI receive FSM and control-register write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= 5'd0;
      r_shift   <= 16'd0;
      r_en_out  <= 16'd0;
      r_en_pwm  <= 16'd0;
      r_duty    <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ncs_fall) begin
            r_bit_cnt <= 5'd0;
            r_shift   <= 16'd0;
            r_state   <= ST_RX;
          end
        end
        ST_RX: begin
          if (w_ncs_rise) begin
            r_state <= ST_IDLE;
            if (w_frame_ok) begin
              case (r_shift[14:8])
                7'd0:    r_en_out[7:0]  <= r_shift[7:0];
                7'd1:    r_en_out[15:8] <= r_shift[7:0];
                7'd2:    r_en_pwm[7:0]  <= r_shift[7:0];
                7'd3:    r_en_pwm[15:8] <= r_shift[7:0];
                7'd4:    r_duty         <= r_shift[7:0];
                default: ;
              endcase
            end
          end else if (w_sclk_rise && !r_sync2[2]) begin
            r_shift <= {r_shift[14:0], r_sync2[1]};
            if (r_bit_cnt != 5'd17) r_bit_cnt <= r_bit_cnt + 5'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // duty 0xFF is forced high so full scale really means always on.
  assign w_pwm      = (r_duty == 8'hFF) | (r_cnt < r_duty);
  assign w_out_next = w_gate ? (r_en_out & (~r_en_pwm | {16{w_pwm}})) : 16'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_cnt <= 8'd0;
      r_out <= 16'd0;
    end else begin
      if (r_pre == PRE_LAST) begin
        r_pre <= '0;
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_pre <= r_pre + PRE_W'(1);
      end
      r_out <= w_out_next;
    end
  end

  assign io.uo_out  = r_out[7:0];
  assign io.uio_out = r_out[15:8];
  assign io.uio_oe  = 8'hFF;

endmodule
`default_nettype wire

// File: tb/tb_uwasic_onboarding_elvis.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uwasic_onboarding_elvis
// Purpose  : Self-checking bench for uwasic_onboarding_elvis: SPI register
//            writes, frame discard rules, PWM timing, reset abort and the
//            optional ENA_GATE_EN behaviour.
// Revision : 1.0  initial release
// ============================================================================
module tb_uwasic_onboarding_elvis;

  localparam int HALF    = 50;          // 100 clk per SCLK period = 100 kHz
  localparam int PERIOD  = 13 * 256;    // clk cycles per PWM period

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic sclk = 1'b0, copi = 1'b0, ncs = 1'b1;

  always #50 clk = ~clk;                // 10 MHz

  uwasic_onboarding_elvis_if tt_io();
  assign tt_io.ui_in  = {5'b0, ncs, copi, sclk};
  assign tt_io.uio_in = 8'h00;

  uwasic_onboarding_elvis #(.PWM_DIV(13), .MAX_ADDR(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .io    (tt_io)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] m_reg [0:4];

  typedef struct {
    string       name;
    logic [15:0] frame;
    int          nbits;
    logic [7:0]  uo;
    logic [7:0]  uio;
  } vec_t;
  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    copi = b;
    clks(HALF);
    sclk = 1'b1;
    clks(HALF);
    sclk = 1'b0;
  endtask

  // Sends nbits MSB first (zeros past bit 16) and updates the model.
  task automatic do_frame(input logic [15:0] frame, input int nbits);
    ncs = 1'b0;
    clks(HALF);
    for (int i = 0; i < nbits; i++) send_bit(i < 16 ? frame[15 - i] : 1'b0);
    clks(HALF);
    ncs = 1'b1;
    clks(8);
    if (nbits == 16 && frame[15] && frame[14:8] <= 7'd4
`ifdef ENA_GATE_EN
        && ena
`endif
       ) m_reg[frame[10:8]] = frame[7:0];
  endtask

  task automatic measure(input int n, output int high, output int rises);
    logic prev;
    prev = tt_io.uo_out[0];
    high = 0;
    rises = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tt_io.uo_out[0]) high++;
      if (tt_io.uo_out[0] && !prev) rises++;
      prev = tt_io.uo_out[0];
    end
  endtask

  task automatic wait_rise(input int budget, output int waited, output bit ok);
    logic prev;
    prev = tt_io.uo_out[0];
    ok = 1'b0;
    waited = 0;
    while (!ok && waited < budget) begin
      @(negedge clk);
      waited++;
      if (tt_io.uo_out[0] && !prev) ok = 1'b1;
      prev = tt_io.uo_out[0];
    end
  endtask

  // Checks outputs against the channel rules using the model registers.
  task automatic check_rules(input string tag);
    logic [15:0] en_out, en_pwm, pm, act, pw;
    en_out = {m_reg[1], m_reg[0]};
    en_pwm = {m_reg[3], m_reg[2]};
    pm     = en_out & en_pwm;
    act    = {tt_io.uio_out, tt_io.uo_out};
    pw     = act & pm;
    check({tag, "_static"}, act & ~pm, en_out & ~en_pwm);
    if (pm != 16'd0) begin
      if (m_reg[4] == 8'h00)      check({tag, "_pwm0"}, pw, 16'd0);
      else if (m_reg[4] == 8'hFF) check({tag, "_pwmFF"}, pw, pm);
      else check({tag, "_pwm_uniform"}, (pw == 16'd0 || pw == pm), 1'b1);
    end
  endtask

  initial begin
    int high, rises, waited;
    bit ok;
    logic [15:0] rframe;
    int nb;

    tbl[0]  = '{"wr0_F0",   16'h80F0, 16, 8'hF0, 8'h00};
    tbl[1]  = '{"wr1_CC",   16'h81CC, 16, 8'hF0, 8'hCC};
    tbl[2]  = '{"read",     16'h00F0, 16, 8'hF0, 8'hCC};
    tbl[3]  = '{"addr30",   16'hB0AA, 16, 8'hF0, 8'hCC};
    tbl[4]  = '{"short15",  16'h8055, 15, 8'hF0, 8'hCC};
    tbl[5]  = '{"long17",   16'h8055, 17, 8'hF0, 8'hCC};
    tbl[6]  = '{"addr5",    16'h85FF, 16, 8'hF0, 8'hCC};
    tbl[7]  = '{"wr0_3C",   16'h803C, 16, 8'h3C, 8'hCC};
    tbl[8]  = '{"wr2_0F",   16'h820F, 16, 8'h30, 8'hCC};
    tbl[9]  = '{"duty_FF",  16'h84FF, 16, 8'h3C, 8'hCC};
    tbl[10] = '{"duty_00",  16'h8400, 16, 8'h30, 8'hCC};

    for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;

    // Reset state
    clks(5);
    check("rst_uo", tt_io.uo_out, 8'h00);
    check("rst_uio", tt_io.uio_out, 8'h00);
    check("rst_oe", tt_io.uio_oe, 8'hFF);
    rst_n = 1'b1;
    clks(20);
    check("post_rst_uo", tt_io.uo_out, 8'h00);
    check("post_rst_uio", tt_io.uio_out, 8'h00);

    // Table-driven register writes and discards
    for (int i = 0; i < 11; i++) begin
      do_frame(tbl[i].frame, tbl[i].nbits);
      check({tbl[i].name, "_uo"}, tt_io.uo_out, tbl[i].uo);
      check({tbl[i].name, "_uio"}, tt_io.uio_out, tbl[i].uio);
      check({tbl[i].name, "_oe"}, tt_io.uio_oe, 8'hFF);
    end

    // PWM on channel 0 at 50 %
    do_frame(16'h8001, 16);
    do_frame(16'h8201, 16);
    do_frame(16'h8480, 16);
    clks(20);
    measure(PERIOD, high, rises);
    check("pwm80_high", high, 128 * 13);
    check("pwm80_rises", rises, 1);
    wait_rise(PERIOD + 100, waited, ok);
    check("pwm80_edge1_seen", ok, 1'b1);
    wait_rise(PERIOD + 100, waited, ok);
    check("pwm80_edge2_seen", ok, 1'b1);
    check("pwm80_period", waited, PERIOD);
    check("pwm80_other_uo", tt_io.uo_out[7:1], 7'h00);

    do_frame(16'h8400, 16);
    clks(20);
    measure(PERIOD, high, rises);
    check("pwm00_high", high, 0);

    do_frame(16'h84FF, 16);
    clks(20);
    measure(PERIOD, high, rises);
    check("pwmFF_high", high, PERIOD);
    check("pwmFF_rises", rises, 0);

    do_frame(16'h8401, 16);
    clks(20);
    measure(PERIOD, high, rises);
    check("pwm01_high", high, 13);

    // Randomized frames against the register model
    for (int k = 0; k < 10; k++) begin
      rframe = {($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
                7'($urandom_range(0, 5)), 8'($urandom)};
      case ($urandom_range(0, 9))
        0:       nb = 15;
        1:       nb = 17;
        default: nb = 16;
      endcase
      do_frame(rframe, nb);
      clks(4);
      check_rules($sformatf("rnd%0d", k));
    end

    // Reset in the middle of a frame
    ncs = 1'b0;
    clks(HALF);
    for (int i = 0; i < 8; i++) send_bit(i == 0 ? 1'b1 : 1'b0);
    rst_n = 1'b0;
    clks(3);
    check("midrst_uo", tt_io.uo_out, 8'h00);
    check("midrst_uio", tt_io.uio_out, 8'h00);
    ncs = 1'b1;
    clks(3);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
    clks(20);
    check("after_rst_uo", tt_io.uo_out, 8'h00);
    do_frame(16'h8001, 16);
    check("rst_wr_uo", tt_io.uo_out, 8'h01);
    check("rst_wr_uio", tt_io.uio_out, 8'h00);

`ifdef ENA_GATE_EN
    do_frame(16'h805A, 16);
    do_frame(16'h81A5, 16);
    ena = 1'b0;
    clks(5);
    check("ena0_uo", tt_io.uo_out, 8'h00);
    check("ena0_uio", tt_io.uio_out, 8'h00);
    do_frame(16'h80FF, 16);
    ena = 1'b1;
    clks(5);
    check("ena1_uo", tt_io.uo_out, 8'h5A);
    check("ena1_uio", tt_io.uio_out, 8'hA5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
